// File: rtl/key_event_counter.sv
// Debounced active-low key press counter: captures sw_i on each press and
// steps a hex up/down counter (wrap or saturate) shown on seven-segment digits.
module key_event_counter #(
  parameter int unsigned SW_W         = 10,
  parameter int unsigned DIGITS       = 2,
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic                  clk100_i,
  input  logic                  rstn_i,
  input  logic                  key_i,
  input  logic [SW_W-1:0]       sw_i,
  input  logic                  dir_i,
  input  logic                  sat_i,
  output logic [SW_W-1:0]       ledr_o,
  output logic [4*DIGITS-1:0]   cnt_o,
  output logic                  ovf_o,
  output logic [7*DIGITS-1:0]   hex_o
);

  localparam int unsigned CW  = 4 * DIGITS;
  localparam int unsigned DBW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [1:0]        r_sync;
  logic              r_key_db;
  logic [DBW-1:0]    r_db_cnt;
  logic [SW_W-1:0]   r_ledr;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf;

  logic              w_s;
  logic              w_accept;
  logic              w_press;
  logic              w_at_lim;
  logic [CW-1:0]     w_cnt_nxt;
  logic [7*DIGITS-1:0] w_hex;

  assign w_s      = r_sync[1];
  assign w_accept = (w_s != r_key_db) && (r_db_cnt == DBW'(DEBOUNCE_CYC - 1));
  // The press is applied on the same edge that the debounced level falls.
  assign w_press  = w_accept && !w_s;

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync   <= '1;
      r_key_db <= 1'b1;
      r_db_cnt <= '0;
    end else begin
      r_sync <= {r_sync[0], key_i};
      if (w_s == r_key_db) begin
        r_db_cnt <= '0;
      end else if (w_accept) begin
        r_key_db <= w_s;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DBW'(1);
      end
    end
  end

  always_comb begin
    w_at_lim  = dir_i ? (r_cnt == '0) : (r_cnt == '1);
    w_cnt_nxt = dir_i ? (r_cnt - CW'(1)) : (r_cnt + CW'(1));
    if (w_at_lim && sat_i) begin
      w_cnt_nxt = r_cnt;
    end
  end

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ledr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else if (w_press) begin
      r_ledr <= sw_i;
      r_cnt  <= w_cnt_nxt;
      if (w_at_lim) begin
        r_ovf <= 1'b1;
      end
    end
  end

  function automatic logic [6:0] f_seg(input logic [3:0] n);
    case (n)
      4'h0: f_seg = 7'b1000000;
      4'h1: f_seg = 7'b1111001;
      4'h2: f_seg = 7'b0100100;
      4'h3: f_seg = 7'b0110000;
      4'h4: f_seg = 7'b0011001;
      4'h5: f_seg = 7'b0010010;
      4'h6: f_seg = 7'b0000010;
      4'h7: f_seg = 7'b1111000;
      4'h8: f_seg = 7'b0000000;
      4'h9: f_seg = 7'b0010000;
      4'hA: f_seg = 7'b0001000;
      4'hB: f_seg = 7'b0000011;
      4'hC: f_seg = 7'b1000110;
      4'hD: f_seg = 7'b0100001;
      4'hE: f_seg = 7'b0000110;
      default: f_seg = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    w_hex = '1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      w_hex[7*k +: 7] = f_seg(r_cnt[4*k +: 4]);
    end
  end

  assign ledr_o = r_ledr;
  assign cnt_o  = r_cnt;
  assign ovf_o  = r_ovf;
  assign hex_o  = w_hex;

endmodule

// File: tb/tb_key_event_counter.sv
// Directed + randomized bench for key_event_counter; a behavioural model of
// press events (integer count, limit rules) predicts every output.
module tb_key_event_counter;

  localparam int unsigned D     = 4;
  localparam int unsigned SW_W  = 10;
  localparam int unsigned DIG   = 2;
  localparam int          MAXV  = 255;

  logic                clk = 1'b0;
  logic                rstn;
  logic                key;
  logic [SW_W-1:0]     sw;
  logic                dir;
  logic                sat;
  logic [SW_W-1:0]     ledr;
  logic [4*DIG-1:0]    cnt;
  logic                ovf;
  logic [7*DIG-1:0]    hex;

  int n_tests = 0;
  int n_fail  = 0;

  int              m_cnt;
  logic            m_ovf;
  logic [SW_W-1:0] m_ledr;

  always #5 clk = ~clk;

  key_event_counter #(
    .SW_W(SW_W),
    .DIGITS(DIG),
    .DEBOUNCE_CYC(D)
  ) dut (
    .clk100_i(clk),
    .rstn_i(rstn),
    .key_i(key),
    .sw_i(sw),
    .dir_i(dir),
    .sat_i(sat),
    .ledr_o(ledr),
    .cnt_o(cnt),
    .ovf_o(ovf),
    .hex_o(hex)
  );

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: glyph = 7'b1000000;  1: glyph = 7'b1111001;
      2: glyph = 7'b0100100;  3: glyph = 7'b0110000;
      4: glyph = 7'b0011001;  5: glyph = 7'b0010010;
      6: glyph = 7'b0000010;  7: glyph = 7'b1111000;
      8: glyph = 7'b0000000;  9: glyph = 7'b0010000;
      10: glyph = 7'b0001000; 11: glyph = 7'b0000011;
      12: glyph = 7'b1000110; 13: glyph = 7'b0100001;
      14: glyph = 7'b0000110; default: glyph = 7'b0001110;
    endcase
  endfunction

  function automatic logic [13:0] exp_hex(input int c);
    exp_hex = {glyph(c / 16), glyph(c % 16)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_cnt"},  32'(cnt),  32'(m_cnt));
    check({tag, "_ledr"}, 32'(ledr), 32'(m_ledr));
    check({tag, "_ovf"},  32'(ovf),  32'(m_ovf));
    check({tag, "_hex"},  32'(hex),  32'(exp_hex(m_cnt)));
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_ledr = '0;
  endtask

  // One accepted press: capture switches, step count with limit handling.
  task automatic model_event();
    m_ledr = sw;
    if (dir == 1'b0) begin
      if (m_cnt == MAXV) begin
        m_ovf = 1'b1;
        m_cnt = sat ? MAXV : 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      if (m_cnt == 0) begin
        m_ovf = 1'b1;
        m_cnt = sat ? 0 : MAXV;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic do_reset();
    key  = 1'b1;
    rstn = 1'b0;
    tick();
    tick();
    model_reset();
    check_all("reset");
    rstn = 1'b1;
  endtask

  task automatic press(input logic [SW_W-1:0] s, input logic d, input logic st, input string tag);
    sw  = s;
    dir = d;
    sat = st;
    key = 1'b0;
    repeat ($urandom_range(D + 8, D + 2)) tick();
    key = 1'b1;
    repeat ($urandom_range(D + 8, D + 3)) tick();
    model_event();
    check_all(tag);
  endtask

  initial begin
    rstn = 1'b0;
    key  = 1'b1;
    sw   = '0;
    dir  = 1'b0;
    sat  = 1'b0;
    model_reset();

    // 1: exact latency; key low before edge 10 -> event at edge 15
    do_reset();
    repeat (9) tick();
    sw  = SW_W'($urandom);
    key = 1'b0;
    for (int e = 10; e <= 14; e++) begin
      tick();
      check("t1_hold_cnt", 32'(cnt), 32'd0);
    end
    tick();
    model_event();
    check_all("t1_event");
    key = 1'b1;
    repeat (D + 3) tick();

    // 2: short glitches rejected, long hold gives one event
    sw = SW_W'($urandom);
    for (int l = 1; l <= 3; l++) begin
      key = 1'b0;
      repeat (l) tick();
      key = 1'b1;
      repeat (2) tick();
      check("t2_glitch_cnt", 32'(cnt), 32'(m_cnt));
    end
    key = 1'b0;
    repeat (200) tick();
    key = 1'b1;
    repeat (D + 3) tick();
    model_event();
    check_all("t2_hold");

    // 3: wrap upward through 256 presses
    do_reset();
    for (int i = 0; i < 256; i++) press(SW_W'($urandom), 1'b0, 1'b0, "t3");
    check("t3_final_cnt", 32'(cnt), 32'h00);
    check("t3_final_ovf", 32'(ovf), 32'd1);

    // 4: saturate downward from zero
    do_reset();
    for (int i = 0; i < 3; i++) press(SW_W'($urandom), 1'b1, 1'b1, "t4");
    check("t4_final_cnt", 32'(cnt), 32'h00);
    check("t4_final_ovf", 32'(ovf), 32'd1);

    // 5: display of 0x3A
    do_reset();
    for (int i = 0; i < 58; i++) press(SW_W'($urandom), 1'b0, 1'b0, "t5");
    check("t5_cnt", 32'(cnt), 32'h3A);
    check("t5_hex_hi", 32'(hex[13:7]), 32'(7'b0110000));
    check("t5_hex_lo", 32'(hex[6:0]), 32'(7'b0001000));

    // random mix of directions and modes
    for (int i = 0; i < 150; i++)
      press(SW_W'($urandom), 1'($urandom), 1'($urandom), "rand");

    // 6: async reset mid-debounce discards pending press
    sw  = SW_W'($urandom);
    dir = 1'b0;
    sat = 1'b0;
    key = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    #1;
    model_reset();
    check_all("t6_async");
    #1;
    rstn = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("t6_hold_cnt", 32'(cnt), 32'd0);
    end
    tick();
    model_event();
    check_all("t6_event");
    key = 1'b1;
    repeat (D + 3) tick();
    check_all("t6_final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
